// File: rtl/csa_pkg.sv
// Shared definitions for the sequential carry-skip adder/subtractor.
// Provides the FSM state encoding and the default datapath geometry.
package csa_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned BLK_DEF   = 8;
  localparam int unsigned NBLK_DEF  = WIDTH_DEF / BLK_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/csa_skip_blk.sv
// Combinational BLK-bit carry-skip adder block.
// Ports:
//   a, b   : BLK-bit operand slices
//   ci     : carry into the block
//   s      : BLK-bit sum slice
//   co     : carry out (bypasses the ripple chain when every bit propagates)
//   p_all  : all propagate bits set, i.e. the skip condition
module csa_skip_blk #(
  parameter int unsigned BLK = 8
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co,
  output logic           p_all
);

  logic [BLK-1:0] p;
  logic [BLK-1:0] g;
  logic [BLK:0]   c;

  assign p     = a ^ b;
  assign g     = a & b;
  assign p_all = &p;

  // Ripple chain; only its sum bits and its carry on a non-propagating block are used.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < int'(BLK); i++) begin
      s[i]   = p[i] ^ c[i];
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  // When every bit propagates, the ripple carry equals ci; take it directly.
  assign co = p_all ? ci : c[BLK];

endmodule

// File: rtl/csa_addsub32_seq.sv
// Multi-cycle adder/subtractor: one carry-skip block per clock, LSB block first.
// Computes a+b+cin (sub=0) or a-b-cin (sub=1, encoded as a + ~b + !cin).
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   in_valid, in_ready   : operand handshake (in_ready high only in IDLE)
//   a, b, cin, sub       : operands, carry/borrow-in, operation select
//   out_valid, out_ready : result handshake
//   result, cout, ovf    : sum/difference, carry-out (sub: 1 = no borrow), signed overflow
module csa_addsub32_seq
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned BLK   = BLK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NBLK  = WIDTH / BLK;
  localparam int unsigned IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;

  state_e state, state_d;

  logic [WIDTH-1:0] opa, opa_d;
  logic [WIDTH-1:0] opb, opb_d;
  logic [WIDTH-1:0] acc, acc_d;
  logic             carry, carry_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [WIDTH-1:0] result_d;
  logic             cout_d;
  logic             ovf_d;
  logic             out_valid_d;

  logic [BLK-1:0]   blk_a;
  logic [BLK-1:0]   blk_b;
  logic [BLK-1:0]   blk_s;
  logic             blk_co;
  logic             blk_p_all;
  logic             blk_carry;
  logic             last_blk;

  // Single block instance, time-multiplexed over the operand slices by idx.
  assign blk_a = opa[idx*BLK +: BLK];
  assign blk_b = opb[idx*BLK +: BLK];

  csa_skip_blk #(.BLK(BLK)) u_blk (
    .a     (blk_a),
    .b     (blk_b),
    .ci    (carry),
    .s     (blk_s),
    .co    (blk_co),
    .p_all (blk_p_all)
  );

  assign blk_carry = blk_p_all ? carry : blk_co;
  assign last_blk  = (idx == IDX_W'(NBLK - 1));
  assign in_ready  = (state == ST_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_blk)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    opa_d       = opa;
    opb_d       = opb;
    acc_d       = acc;
    carry_d     = carry;
    idx_d       = idx;
    result_d    = result;
    cout_d      = cout;
    ovf_d       = ovf;
    out_valid_d = out_valid;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ST_RUN: begin
        acc_d[idx*BLK +: BLK] = blk_s;
        carry_d               = blk_carry;
        idx_d                 = idx + IDX_W'(1);
        // Publish only the complete result; the partial sum stays internal.
        if (last_blk) begin
          result_d    = acc_d;
          cout_d      = blk_carry;
          ovf_d       = (opa[WIDTH-1] == opb[WIDTH-1]) && (blk_s[BLK-1] != opa[WIDTH-1]);
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      opa       <= opa_d;
      opb       <= opb_d;
      acc       <= acc_d;
      carry     <= carry_d;
      idx       <= idx_d;
      result    <= result_d;
      cout      <= cout_d;
      ovf       <= ovf_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_csa_addsub32_seq.sv
`timescale 1ns/1ps
module tb_csa_addsub32_seq;

  localparam int unsigned LAT = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        cout;
  logic        ovf;

  int nvec;
  int nerr;

  csa_addsub32_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer arithmetic; returns {ovf, cout, result}.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c, input logic s);
    logic [63:0] u;
    longint      sx, sy, sr;
    logic        co, ov;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!s) begin
      u  = 64'(x) + 64'(y) + 64'(c);
      co = u[32];
      sr = sx + sy + longint'(c);
    end else begin
      u  = 64'(x) - 64'(y) - 64'(c);
      co = !u[63];
      sr = sx - sy - longint'(c);
    end
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {ov, co, u[31:0]};
  endfunction

  // Drive one operation and return what the DUT presented.
  task automatic issue(input logic [31:0] xa, input logic [31:0] xb, input logic xc,
                       input logic xs, input bit finish,
                       output logic [33:0] got, output int lat, output bit tmo,
                       output logic rdy_after, output logic vld_after);
    int n;
    tmo = 0;
    got = '0;
    lat = 0;
    rdy_after = 1'b0;
    vld_after = 1'b1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tmo = 1;
      return;
    end
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      tmo = 1;
      return;
    end
    got = {ovf, cout, result};
    if (finish) begin
      @(posedge clk);
      #1;
      rdy_after = in_ready;
      vld_after = out_valid;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if ({out_valid, ovf, cout, result} !== 35'd0) begin
      nerr++;
      $display("FAIL reset_outputs: got ov=%b ovf=%b cout=%b res=%h, want all 0",
               out_valid, ovf, cout, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [7] = '{32'h00000000, 32'h0000FFFF, 32'hFFFFFFFF, 32'hAAAAAAAA,
                            32'h12345678, 32'h00000005, 32'h80000000};
    logic [31:0] tb [7] = '{32'h00000000, 32'h00000001, 32'h00000001, 32'h55555555,
                            32'h87645201, 32'h00000007, 32'h00000001};
    logic        tc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        ts [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [33:0] te [7] = '{{2'b00, 32'h00000000}, {2'b00, 32'h00010000},
                            {2'b01, 32'h00000001}, {2'b00, 32'hFFFFFFFF},
                            {2'b00, 32'h9998A87A}, {2'b00, 32'hFFFFFFFE},
                            {2'b11, 32'h7FFFFFFF}};
    logic [33:0] got;
    int lat;
    bit tmo;
    logic ra, va;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      issue(ta[i], tb[i], tc[i], ts[i], 1, got, lat, tmo, ra, va);
      nvec++;
      if (tmo) begin
        nerr++;
        $display("FAIL dir%0d_timeout: no out_valid within bound", i);
        continue;
      end
      if (got !== te[i]) begin
        nerr++;
        $display("FAIL dir%0d_value: got ovf/cout/res=%h want %h", i, got, te[i]);
      end
      nvec++;
      if (lat != int'(LAT)) begin
        nerr++;
        $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LAT);
      end
      nvec++;
      if (ra !== 1'b1 || va !== 1'b0) begin
        nerr++;
        $display("FAIL dir%0d_post_handshake: got in_ready=%b out_valid=%b want 1/0", i, ra, va);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] xa, xb;
    logic xc, xs;
    logic [33:0] got, exp;
    int lat;
    bit tmo;
    logic ra, va;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      xa = $urandom; xb = $urandom; xc = 1'($urandom); xs = 1'($urandom);
      if (i % 8 == 0) xb = ~xa;
      exp = model(xa, xb, xc, xs);
      issue(xa, xb, xc, xs, 1, got, lat, tmo, ra, va);
      nvec++;
      if (tmo || got !== exp || lat != int'(LAT)) begin
        nerr++;
        $display("FAIL rand%0d: a=%h b=%h cin=%b sub=%b got=%h lat=%0d tmo=%0d want=%h lat=%0d",
                 i, xa, xb, xc, xs, got, lat, tmo, exp, LAT);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] got, exp;
    int lat;
    bit tmo;
    logic ra, va;
    exp = model(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    out_ready = 1'b0;
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, got, lat, tmo, ra, va);
    nvec++;
    if (tmo || got !== exp) begin
      nerr++;
      $display("FAIL bp_value: got=%h tmo=%0d want=%h", got, tmo, exp);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      @(posedge clk);
      #1;
      nvec++;
      if ({ovf, cout, result} !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        nerr++;
        $display("FAIL bp_hold%0d: got res=%h in_ready=%b out_valid=%b want res=%h 0/1",
                 k, {ovf, cout, result}, in_ready, out_valid, exp);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_abort();
    logic [33:0] got, exp;
    int lat;
    bit tmo;
    logic ra, va;
    out_ready = 1'b1;
    @(negedge clk);
    a = 32'hDEADBEEF; b = 32'h01234567; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({out_valid, ovf, cout, result} !== 35'd0) begin
      nerr++;
      $display("FAIL abort_outputs: got ov=%b ovf=%b cout=%b res=%h want all 0",
               out_valid, ovf, cout, result);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      nvec++;
      if (out_valid !== 1'b0) begin
        nerr++;
        $display("FAIL abort_no_valid: got out_valid=%b want 0", out_valid);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp = model(32'h40000000, 32'h40000000, 1'b0, 1'b0);
    issue(32'h40000000, 32'h40000000, 1'b0, 1'b0, 1, got, lat, tmo, ra, va);
    nvec++;
    if (tmo || got !== exp || lat != int'(LAT)) begin
      nerr++;
      $display("FAIL abort_next_op: got=%h lat=%0d tmo=%0d want=%h lat=%0d",
               got, lat, tmo, exp, LAT);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
